// File: rtl/jtframe_cen_meter.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_cen_meter
// Purpose  : Measures a cen pulse stream per window strobe: pulse count,
//            min/max pulse spacing and signed deficit vs. an expected count.
//            Gap statistics are built only when JTFRAME_CEN_METER_GAP_EN is
//            defined; otherwise gap_min/gap_max are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_cen_meter #(
  parameter int CW = 16,
  parameter int GW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          win,
  input  logic [CW-1:0] expected,
  input  logic          ack,
  output logic          valid,
  output logic [CW-1:0] count,
  output logic [CW-1:0] deficit,
  output logic [GW-1:0] gap_min,
  output logic [GW-1:0] gap_max,
  output logic          lost
);

  localparam logic [CW-1:0] c_pos_lim = {1'b0, {(CW-1){1'b1}}};
  localparam logic [CW-1:0] c_neg_lim = {1'b1, {(CW-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_pcnt;
  logic [CW-1:0] w_cnt_new;
  logic [CW:0]   w_diff;
  logic [CW-1:0] w_deficit;

  // Pulse total for the window including a cen arriving in this very cycle
  assign w_cnt_new = (cen && (r_pcnt != {CW{1'b1}})) ? r_pcnt + CW'(1) : r_pcnt;
  assign w_diff    = {1'b0, expected} - {1'b0, w_cnt_new};

  // Out of CW-bit signed range when the two top bits of the wide result differ
  always_comb begin
    w_deficit = w_diff[CW-1:0];
    if (w_diff[CW] != w_diff[CW-1]) begin
      w_deficit = w_diff[CW] ? c_neg_lim : c_pos_lim;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      valid   <= 1'b0;
      lost    <= 1'b0;
      count   <= '0;
      deficit <= '0;
    end else begin
      r_pcnt <= win ? '0 : w_cnt_new;
      if (win) begin
        if (r_state == IDLE) begin
          r_state <= MEASURE;
        end else begin
          count   <= w_cnt_new;
          deficit <= w_deficit;
          valid   <= 1'b1;
          if (valid) begin
            lost <= !ack;
          end
        end
      end else if (ack && valid) begin
        valid <= 1'b0;
        lost  <= 1'b0;
      end
    end
  end

`ifdef JTFRAME_CEN_METER_GAP_EN
  logic [GW-1:0] r_gcnt;
  logic [GW-1:0] r_gmin;
  logic [GW-1:0] r_gmax;
  logic          r_seen;
  logic          w_gap_hit;
  logic [GW-1:0] w_gmin_new;
  logic [GW-1:0] w_gmax_new;

  // A spacing exists only once some earlier cen has been seen since reset
  assign w_gap_hit  = cen && r_seen;
  assign w_gmin_new = (w_gap_hit && (r_gcnt < r_gmin)) ? r_gcnt : r_gmin;
  assign w_gmax_new = (w_gap_hit && (r_gcnt > r_gmax)) ? r_gcnt : r_gmax;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gcnt  <= '0;
      r_gmin  <= '1;
      r_gmax  <= '0;
      r_seen  <= 1'b0;
      gap_min <= '0;
      gap_max <= '0;
    end else begin
      if (cen) begin
        r_gcnt <= GW'(1);
      end else if (r_gcnt != {GW{1'b1}}) begin
        r_gcnt <= r_gcnt + GW'(1);
      end
      r_seen <= r_seen | cen;
      if (win) begin
        if (r_state == MEASURE) begin
          gap_min <= w_gmin_new;
          gap_max <= w_gmax_new;
        end
        r_gmin <= '1;
        r_gmax <= '0;
      end else begin
        r_gmin <= w_gmin_new;
        r_gmax <= w_gmax_new;
      end
    end
  end
`else
  assign gap_min = '0;
  assign gap_max = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtframe_cen_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_cen_meter
// Purpose  : Randomized scoreboard bench for jtframe_cen_meter against a
//            timestamp-based window model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_cen_meter;

  localparam int CW    = 8;
  localparam int GW    = 6;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int GMAXV = (1 << GW) - 1;
  localparam int DPOS  = (1 << (CW - 1)) - 1;
  localparam int DNEG  = -(1 << (CW - 1));

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic          win = 1'b0;
  logic          ack = 1'b0;
  logic [CW-1:0] expected = '0;
  logic          valid;
  logic          lost;
  logic [CW-1:0] count;
  logic [CW-1:0] deficit;
  logic [GW-1:0] gap_min;
  logic [GW-1:0] gap_max;

  always #5 clk = ~clk;

  jtframe_cen_meter #(.CW(CW), .GW(GW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .win(win), .expected(expected), .ack(ack),
    .valid(valid), .count(count), .deficit(deficit),
    .gap_min(gap_min), .gap_max(gap_max), .lost(lost)
  );

  typedef struct {
    time due;
    bit  v;
    bit  l;
    int  c;
    int  d;
    int  gmin;
    int  gmax;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: windows as pulse tallies, spacing from cycle timestamps
  bit m_meas = 0, m_prior = 0, m_valid = 0, m_lost = 0;
  int m_n = 0, m_gmin = GMAXV, m_gmax = 0, m_last = 0, m_cyc = 0;
  int res_c = 0, res_d = 0, res_gmin = 0, res_gmax = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic bit rnd_ack(input int n);
    return m_valid && ($urandom_range(0, n - 1) == 0);
  endfunction

  task automatic step(input bit r, input bit c, input bit w, input bit a, input int e);
    exp_t x;
    int   g;
    @(posedge clk);
    #1;
    rst = r; cen = c; win = w; ack = a; expected = CW'(e);
    if (r) begin
      m_meas = 0; m_prior = 0; m_n = 0; m_gmin = GMAXV; m_gmax = 0;
      m_valid = 0; m_lost = 0;
      res_c = 0; res_d = 0; res_gmin = 0; res_gmax = 0;
    end else begin
      if (c) begin
        if (m_prior) begin
          g = m_cyc - m_last;
          if (g > GMAXV) g = GMAXV;
          if (g < m_gmin) m_gmin = g;
          if (g > m_gmax) m_gmax = g;
        end
        m_last  = m_cyc;
        m_prior = 1;
        m_n++;
      end
      if (w) begin
        if (m_meas) begin
          res_c = (m_n > CMAX) ? CMAX : m_n;
          res_d = (e & CMAX) - res_c;
          if (res_d > DPOS) res_d = DPOS;
          if (res_d < DNEG) res_d = DNEG;
          res_gmin = m_gmin;
          res_gmax = m_gmax;
          if (m_valid) m_lost = !a;
          m_valid = 1;
        end else begin
          m_meas = 1;
        end
        m_n = 0; m_gmin = GMAXV; m_gmax = 0;
      end else if (a && m_valid) begin
        m_valid = 0;
        m_lost  = 0;
      end
    end
    m_cyc++;
    x.due = $time + 9;
    x.v = m_valid; x.l = m_lost; x.c = res_c; x.d = res_d;
`ifdef JTFRAME_CEN_METER_GAP_EN
    x.gmin = res_gmin; x.gmax = res_gmax;
`else
    x.gmin = 0; x.gmax = 0;
`endif
    sb.push_back(x);
  endtask

  // Monitor: compares every result the DUT presents after each active edge
  initial begin
    exp_t y;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due < $time) begin
        y = sb.pop_front();
        chk("valid",   valid,            y.v);
        chk("lost",    lost,             y.l);
        chk("count",   count,            y.c);
        chk("deficit", $signed(deficit), y.d);
        chk("gap_min", gap_min,          y.gmin);
        chk("gap_max", gap_max,          y.gmax);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  nxt, ph, mode, win_gap;
    bit  c, w, prev_w;
    repeat (4) step(1, 0, 0, 0, 0);

    // Regular cen every 4, window every 400, expected 100
    for (int t = 0; t < 1300; t++)
      step(0, (t % 4) == 0, (t % 400) == 399, rnd_ack(16), 100);

    // Fractional 3,3,4 spacing
    nxt = 0; ph = 0;
    for (int t = 0; t < 1600; t++) begin
      c = (t == nxt);
      if (c) begin
        nxt = t + ((ph == 2) ? 4 : 3);
        ph  = (ph + 1) % 3;
      end
      step(0, c, (t % 500) == 499, rnd_ack(16), 150);
    end

    // Overrun without ack, then a single acknowledge
    for (int t = 0; t < 700; t++)
      step(0, $urandom_range(0, 2) == 0, (t % 200) == 199, 0, 60);
    step(0, 0, 0, 1, 60);
    repeat (5) step(0, 0, 0, 0, 60);

    // cen coinciding with win
    for (int t = 0; t < 300; t++)
      step(0, (t % 5) == 4, (t % 50) == 49, rnd_ack(4), 10);

    // Dense cen: count saturation and negative deficit clamp
    for (int t = 0; t < 1600; t++)
      step(0, $urandom_range(0, 9) != 0, (t % 400) == 399, rnd_ack(8), $urandom_range(0, CMAX));

    // Sparse cen: gap saturation and positive deficit clamp
    for (int t = 0; t < 1500; t++)
      step(0, $urandom_range(0, 99) == 0, (t % 300) == 299, rnd_ack(8), $urandom_range(200, CMAX));

    // Reset mid-window, then resume
    for (int t = 0; t < 180; t++)
      step(0, (t % 3) == 0, t == 99, 0, 50);
    repeat (2) step(1, 1, 0, 0, 50);
    for (int t = 0; t < 900; t++)
      step(0, (t % 3) == 0, (t % 300) == 299, rnd_ack(10), 100);

    // Random mix including back-to-back windows and occasional reset
    prev_w = 0; mode = 0; win_gap = 150;
    for (int t = 0; t < 5000; t++) begin
      if ((t % 500) == 0) begin
        mode    = $urandom_range(0, 3);
        win_gap = $urandom_range(20, 200);
      end
      case (mode)
        0:       c = $urandom_range(0, 1) == 0;
        1:       c = $urandom_range(0, 4) == 0;
        2:       c = $urandom_range(0, 79) == 0;
        default: c = $urandom_range(0, 9) != 0;
      endcase
      w = prev_w ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, win_gap - 1) == 0);
      prev_w = w;
      step($urandom_range(0, 2999) == 0, c, w, rnd_ack(8), $urandom_range(0, CMAX));
    end

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
